voice_allocator: RTL and testbench

//  Two-voice scheduler between the PS/2 KeyboardDecoder and buzzer_control.

---
 rtl/piano_pkg.sv | 33 +++
 rtl/voice_allocator_note_rom.sv | 31 +++
 rtl/voice_allocator.sv | 164 ++++++++++++++++
 tb/tb_voice_allocator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: shared constants for the keyboard-to-buzzer voice allocator.
//   - PS/2 scancodes for the seven white keys A..J
//   - note divisors (100 MHz / f_note) for C4..B4
//   - default divisor width and the per-event action encoding
package piano_pkg;

    localparam int DIV_W_DEF = 22;

    localparam logic [8:0] KEY_A = 9'h01C;
    localparam logic [8:0] KEY_S = 9'h01B;
    localparam logic [8:0] KEY_D = 9'h023;
    localparam logic [8:0] KEY_F = 9'h02B;
    localparam logic [8:0] KEY_G = 9'h034;
    localparam logic [8:0] KEY_H = 9'h033;
    localparam logic [8:0] KEY_J = 9'h03B;

    localparam logic [21:0] DIV_C4 = 22'd381679;
    localparam logic [21:0] DIV_D4 = 22'd340136;
    localparam logic [21:0] DIV_E4 = 22'd303030;
    localparam logic [21:0] DIV_F4 = 22'd286532;
    localparam logic [21:0] DIV_G4 = 22'd255102;
    localparam logic [21:0] DIV_A4 = 22'd227272;
    localparam logic [21:0] DIV_B4 = 22'd202429;

    // What the allocation stage does with the event sitting in S1.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_ALLOC,
        ACT_STEAL,
        ACT_FREE
    } act_e;

endpackage

// File: rtl/voice_allocator_note_rom.sv
// note_rom: combinational scancode -> {mapped, divisor} lookup.
// Ports:
//   code_i     9-bit PS/2 scancode
//   mapped_o   1 = code is one of the seven note keys
//   div_o      note divisor (0 when unmapped)
module note_rom
    import piano_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic [8:0]       code_i,
    output logic             mapped_o,
    output logic [DIV_W-1:0] div_o
);

    always_comb begin
        mapped_o = 1'b1;
        div_o    = '0;
        case (code_i)
            KEY_A:   div_o = DIV_W'(DIV_C4);
            KEY_S:   div_o = DIV_W'(DIV_D4);
            KEY_D:   div_o = DIV_W'(DIV_E4);
            KEY_F:   div_o = DIV_W'(DIV_F4);
            KEY_G:   div_o = DIV_W'(DIV_G4);
            KEY_H:   div_o = DIV_W'(DIV_A4);
            KEY_J:   div_o = DIV_W'(DIV_B4);
            default: mapped_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: two-voice scheduler between the PS/2 decoder and the buzzer.
// Press/release events are registered (S1, with note lookup) and then applied
// to the two voices by the allocation stage (S2). Outputs move two cycles
// after key_valid.
// Build option: define VOICE_STEAL_EN to let a press with both voices busy
// replace the oldest voice; otherwise such presses are dropped. overflow_cnt
// counts them in either build.
// Ports:
//   clk, rst        100 MHz clock, async active-high reset
//   enable          0 = mute and free all voices, drop events
//   key_valid       1-cycle event strobe for key_code/key_press
//   key_code        scancode of the event
//   key_press       1 = press, 0 = release
//   note_left/right voice 0/1 divisor (SILENT_DIV when idle)
//   voice_busy      bit i = voice i holds a key
//   overflow_cnt    saturating count of presses that found both voices busy
module voice_allocator
    import piano_pkg::*;
#(
    parameter int               DIV_W      = DIV_W_DEF,
    parameter logic [DIV_W-1:0] SILENT_DIV = '0,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             key_valid,
    input  logic [8:0]       key_code,
    input  logic             key_press,
    output logic [DIV_W-1:0] note_left,
    output logic [DIV_W-1:0] note_right,
    output logic [1:0]       voice_busy,
    output logic [CNT_W-1:0] overflow_cnt
);

    // ---------------- S1: event capture + note lookup ----------------
    logic             rom_mapped;
    logic [DIV_W-1:0] rom_div;

    note_rom #(.DIV_W(DIV_W)) u_rom (
        .code_i   (key_code),
        .mapped_o (rom_mapped),
        .div_o    (rom_div)
    );

    logic             s1_vld_q;
    logic [8:0]       s1_code_q;
    logic             s1_press_q;
    logic             s1_mapped_q;
    logic [DIV_W-1:0] s1_div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_code_q   <= '0;
            s1_press_q  <= 1'b0;
            s1_mapped_q <= 1'b0;
            s1_div_q    <= '0;
        end else begin
            s1_vld_q <= key_valid & enable;
            if (key_valid & enable) begin
                s1_code_q   <= key_code;
                s1_press_q  <= key_press;
                s1_mapped_q <= rom_mapped;
                s1_div_q    <= rom_div;
            end
        end
    end

    // ---------------- S2: allocation ----------------
    logic [1:0]       busy_q;
    logic [8:0]       code_q [2];
    logic [DIV_W-1:0] note_q [2];
    logic             oldest_q;
    logic [CNT_W-1:0] ovf_q;

    // Codes only match on a busy voice; idle voices keep stale codes.
    logic hit0, hit1;
    assign hit0 = busy_q[0] && (code_q[0] == s1_code_q);
    assign hit1 = busy_q[1] && (code_q[1] == s1_code_q);

    act_e act;
    logic tgt;
    logic ovf_inc;

    always_comb begin
        act     = ACT_NONE;
        tgt     = 1'b0;
        ovf_inc = 1'b0;
        if (s1_vld_q) begin
            if (s1_press_q) begin
                // Repeats of a held key and unmapped keys never reach a voice.
                if (s1_mapped_q && !(hit0 || hit1)) begin
                    if (!busy_q[0]) begin
                        act = ACT_ALLOC;
                        tgt = 1'b0;
                    end else if (!busy_q[1]) begin
                        act = ACT_ALLOC;
                        tgt = 1'b1;
                    end else begin
                        ovf_inc = 1'b1;
`ifdef VOICE_STEAL_EN
                        act = ACT_STEAL;
                        tgt = oldest_q;
`endif
                    end
                end
            end else if (hit0) begin
                act = ACT_FREE;
                tgt = 1'b0;
            end else if (hit1) begin
                act = ACT_FREE;
                tgt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            code_q[0] <= '0;
            code_q[1] <= '0;
            note_q[0] <= SILENT_DIV;
            note_q[1] <= SILENT_DIV;
            oldest_q  <= 1'b0;
            ovf_q     <= '0;
        end else if (!enable) begin
            // Mute: free everything; the overflow count is kept.
            busy_q    <= '0;
            code_q[0] <= '0;
            code_q[1] <= '0;
            note_q[0] <= SILENT_DIV;
            note_q[1] <= SILENT_DIV;
            oldest_q  <= 1'b0;
        end else begin
            case (act)
                ACT_ALLOC: begin
                    busy_q[tgt] <= 1'b1;
                    code_q[tgt] <= s1_code_q;
                    note_q[tgt] <= s1_div_q;
                    oldest_q    <= busy_q[~tgt] ? ~tgt : tgt;
                end
                ACT_STEAL: begin
                    code_q[tgt] <= s1_code_q;
                    note_q[tgt] <= s1_div_q;
                    oldest_q    <= ~oldest_q;
                end
                ACT_FREE: begin
                    busy_q[tgt] <= 1'b0;
                    note_q[tgt] <= SILENT_DIV;
                    if (busy_q[~tgt]) oldest_q <= ~tgt;
                end
                default: ;
            endcase
            if (ovf_inc && (ovf_q != {CNT_W{1'b1}})) ovf_q <= ovf_q + 1'b1;
        end
    end

    assign note_left    = note_q[0];
    assign note_right   = note_q[1];
    assign voice_busy   = busy_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        key_valid = 1'b0;
    logic [8:0]  key_code = '0;
    logic        key_press = 1'b0;
    logic [21:0] note_left, note_right;
    logic [1:0]  voice_busy;
    logic [7:0]  overflow_cnt;

    voice_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_press    (key_press),
        .note_left    (note_left),
        .note_right   (note_right),
        .voice_busy   (voice_busy),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0] l;
        logic [21:0] r;
        logic [1:0]  b;
        logic [7:0]  o;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model of the voice state and the one-deep event stage.
    logic        m_busy [2];
    logic [8:0]  m_code [2];
    logic [21:0] m_div  [2];
    int          m_old;
    int          m_ovf;
    logic        p_v, p_press;
    logic [8:0]  p_code;

    function automatic logic [22:0] rom(input logic [8:0] c);
        case (c)
            9'h01C:  return {1'b1, 22'd381679};
            9'h01B:  return {1'b1, 22'd340136};
            9'h023:  return {1'b1, 22'd303030};
            9'h02B:  return {1'b1, 22'd286532};
            9'h034:  return {1'b1, 22'd255102};
            9'h033:  return {1'b1, 22'd227272};
            9'h03B:  return {1'b1, 22'd202429};
            default: return 23'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            m_busy[v] = 1'b0;
            m_code[v] = '0;
            m_div[v]  = '0;
        end
        m_old = 0;
        p_v   = 1'b0;
    endtask

    task automatic model_apply();
        logic [22:0] r;
        int v;
        if (!p_v) return;
        r = rom(p_code);
        if (p_press) begin
            if (!r[22]) return;
            for (int i = 0; i < 2; i++)
                if (m_busy[i] && m_code[i] == p_code) return;
            v = !m_busy[0] ? 0 : (!m_busy[1] ? 1 : -1);
            if (v >= 0) begin
                m_busy[v] = 1'b1;
                m_code[v] = p_code;
                m_div[v]  = r[21:0];
                m_old     = m_busy[1-v] ? 1 - v : v;
            end else begin
                if (m_ovf < 255) m_ovf++;
`ifdef VOICE_STEAL_EN
                m_code[m_old] = p_code;
                m_div[m_old]  = r[21:0];
                m_old         = 1 - m_old;
`endif
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i] && m_code[i] == p_code) begin
                    m_busy[i] = 1'b0;
                    if (m_busy[1-i]) m_old = 1 - i;
                    return;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.l = m_busy[0] ? m_div[0] : 22'd0;
        e.r = m_busy[1] ? m_div[1] : 22'd0;
        e.b = {m_busy[1], m_busy[0]};
        e.o = 8'(m_ovf);
        return e;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".left"},  32'(note_left),    32'(e.l));
        chk({tag, ".right"}, 32'(note_right),   32'(e.r));
        chk({tag, ".busy"},  32'(voice_busy),   32'(e.b));
        chk({tag, ".ovf"},   32'(overflow_cnt), 32'(e.o));
    endtask

    // One clock: drive, advance model at the edge, check just after it.
    task automatic step(input string tag, input logic en, input logic kv,
                        input logic [8:0] code, input logic press);
        enable    = en;
        key_valid = kv;
        key_code  = code;
        key_press = press;
        @(posedge clk);
        if (!en) model_clear();
        else begin
            model_apply();
            p_v     = kv;
            p_code  = code;
            p_press = press;
        end
        sb.push_back(model_out());
        #1;
        compare(tag);
    endtask

    task automatic press(input string tag, input logic [8:0] c);
        step(tag, 1'b1, 1'b1, c, 1'b1);
    endtask

    task automatic release_key(input string tag, input logic [8:0] c);
        step(tag, 1'b1, 1'b1, c, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 9'h000, 1'b0);
    endtask

    logic [8:0] cyc_codes [5];

    initial begin
        model_clear();
        m_ovf = 0;
        cyc_codes[0] = 9'h01B;
        cyc_codes[1] = 9'h02B;
        cyc_codes[2] = 9'h034;
        cyc_codes[3] = 9'h033;
        cyc_codes[4] = 9'h03B;

        // Reset state
        #12;
        sb.push_back(model_out());
        compare("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single press, then a typematic repeat
        press("p1c", 9'h01C);
        idle("p1c_wait", 2);
        press("rep1c", 9'h01C);
        idle("rep1c_wait", 2);

        // Back-to-back presses, then release voice 0
        release_key("rel1c", 9'h01C);
        idle("rel1c_wait", 2);
        press("b2b_1c", 9'h01C);
        press("b2b_23", 9'h023);
        idle("b2b_wait", 2);
        release_key("rel1c_b", 9'h01C);
        idle("rel1c_b_wait", 2);
        release_key("rel_none", 9'h033);
        idle("rel_none_wait", 2);

        // Both busy: steal or drop
        step("clr", 1'b0, 1'b0, 9'h000, 1'b0);
        press("hold1c", 9'h01C);
        press("hold23", 9'h023);
        idle("hold_wait", 2);
        press("ovf33", 9'h033);
        idle("ovf33_wait", 2);
        press("ovf34", 9'h034);
        idle("ovf34_wait", 2);

        // Mute with keys held; press while low is dropped
        step("mute", 1'b0, 1'b0, 9'h000, 1'b0);
        step("mute_press", 1'b0, 1'b1, 9'h01B, 1'b1);
        idle("unmute", 3);

        // Unmapped key, idle and with both busy
        press("unmap", 9'h076);
        idle("unmap_wait", 2);
        press("h1c", 9'h01C);
        press("h23", 9'h023);
        press("unmap_full", 9'h076);
        idle("unmap_full_wait", 2);

        // Saturate the overflow counter
        for (int i = 0; i < 300; i++) press("sat", cyc_codes[i % 5]);
        idle("sat_wait", 2);
        chk("ovf_saturated", 32'(overflow_cnt), 32'd255);

        // Async reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        m_ovf = 0;
        sb.push_back(model_out());
        compare("midrst");
        @(negedge clk);
        rst = 1'b0;
        press("post_rst", 9'h03B);
        idle("post_rst_wait", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
